vga_timing_ctrl: RTL

Timing controller that sequences the 5-bit-per-channel VGA pixel output path. It generates horizontal and vertical scan counters, hsync/vsync, and blanking. It also issues a per-pixel fetch request with (x, y) coordinates to the pixel source and registers the returned colour onto the red/green/blue pins, aligned with the syncs. It sits between the frame/pattern source and the DAC pins and owns all display timing.

---
 rtl/vga_pkg.sv | 18 +
 rtl/vga_axis_counter.sv | 60 ++++++
 rtl/vga_timing_ctrl.sv | 102 ++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared phase type, colour width and default 640x480@60 timing for the VGA
// timing controller.
package vga_pkg;

  typedef enum logic [1:0] {ACTIVE, FP, SYNC, BP} phase_e;

  localparam int RGB_W = 5;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

endpackage

// File: rtl/vga_axis_counter.sv
// One scan axis: a position counter that wraps at the axis total, plus the
// ACTIVE -> FP -> SYNC -> BP phase FSM that follows it.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int ACTIVE_LEN = H_ACTIVE_DEF,
  parameter int FP_LEN     = H_FP_DEF,
  parameter int SYNC_LEN   = H_SYNC_DEF,
  parameter int BP_LEN     = H_BP_DEF,
  parameter int W          = $clog2(ACTIVE_LEN + FP_LEN + SYNC_LEN + BP_LEN)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  output logic [W-1:0] count_o,
  output phase_e       phase_o,
  output logic         wrap_o
);

  localparam int TOTAL = ACTIVE_LEN + FP_LEN + SYNC_LEN + BP_LEN;

  // Phase boundaries expressed as absolute positions on the axis.
  localparam logic [W-1:0] LAST_ACTIVE = W'(ACTIVE_LEN - 1);
  localparam logic [W-1:0] LAST_FP     = W'(ACTIVE_LEN + FP_LEN - 1);
  localparam logic [W-1:0] LAST_SYNC   = W'(ACTIVE_LEN + FP_LEN + SYNC_LEN - 1);
  localparam logic [W-1:0] LAST_POS    = W'(TOTAL - 1);

  logic [W-1:0] count_q, count_d;
  phase_e       phase_q, phase_d;

  assign count_o = count_q;
  assign phase_o = phase_q;
  assign wrap_o  = inc_i && (count_q == LAST_POS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      phase_q <= ACTIVE;
    end else begin
      count_q <= count_d;
      phase_q <= phase_d;
    end
  end

  always_comb begin
    count_d = count_q;
    phase_d = phase_q;
    if (inc_i) begin
      count_d = (count_q == LAST_POS) ? '0 : count_q + 1'b1;
      case (phase_q)
        ACTIVE:  if (count_q == LAST_ACTIVE) phase_d = FP;
        FP:      if (count_q == LAST_FP)     phase_d = SYNC;
        SYNC:    if (count_q == LAST_SYNC)   phase_d = BP;
        BP:      if (count_q == LAST_POS)    phase_d = ACTIVE;
        default: phase_d = ACTIVE;
      endcase
    end
  end

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA display timing: scan counters, pixel fetch requests, and a two-stage
// pipeline that keeps the returned colour aligned with hsync/vsync.
module vga_timing_ctrl
  import vga_pkg::*;
#(
  parameter int H_ACTIVE  = H_ACTIVE_DEF,
  parameter int H_FP      = H_FP_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BP      = H_BP_DEF,
  parameter int V_ACTIVE  = V_ACTIVE_DEF,
  parameter int V_FP      = V_FP_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BP      = V_BP_DEF,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pix_en,
  output logic               pix_req,
  output logic [9:0]         pix_x,
  output logic [9:0]         pix_y,
  input  logic [3*RGB_W-1:0] pix_rgb,
  output logic [RGB_W-1:0]   red,
  output logic [RGB_W-1:0]   green,
  output logic [RGB_W-1:0]   blue,
  output logic               hsync,
  output logic               vsync,
  output logic               frame_start,
  output logic               line_start
);

  localparam int H_W = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam int V_W = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);

  logic [H_W-1:0] hCount;
  logic [V_W-1:0] vCount;
  phase_e         hPhase, vPhase;
  logic           hWrap, vInc, vWrap_unused;
  logic           active, hsLevel, vsLevel;

  logic               act1_q, hs1_q, vs1_q;
  logic [RGB_W-1:0]   red_q, green_q, blue_q;
  logic               hsync_q, vsync_q;

  vga_axis_counter #(
    .ACTIVE_LEN(H_ACTIVE), .FP_LEN(H_FP), .SYNC_LEN(H_SYNC), .BP_LEN(H_BP), .W(H_W)
  ) u_hAxis (
    .clk(clk), .rst_n(rst_n), .inc_i(pix_en),
    .count_o(hCount), .phase_o(hPhase), .wrap_o(hWrap)
  );

  // Lines advance only when the horizontal axis wraps on a pixel strobe.
  assign vInc = hWrap & pix_en;

  vga_axis_counter #(
    .ACTIVE_LEN(V_ACTIVE), .FP_LEN(V_FP), .SYNC_LEN(V_SYNC), .BP_LEN(V_BP), .W(V_W)
  ) u_vAxis (
    .clk(clk), .rst_n(rst_n), .inc_i(vInc),
    .count_o(vCount), .phase_o(vPhase), .wrap_o(vWrap_unused)
  );

  assign active      = (hPhase == ACTIVE) && (vPhase == ACTIVE);
  assign pix_req     = active & pix_en;
  assign pix_x       = active ? 10'(hCount) : 10'd0;
  assign pix_y       = active ? 10'(vCount) : 10'd0;
  assign line_start  = pix_en && (hCount == '0);
  assign frame_start = pix_en && (hCount == '0) && (vCount == '0);
  assign hsLevel     = (hPhase == SYNC) ? HSYNC_POL : ~HSYNC_POL;
  assign vsLevel     = (vPhase == SYNC) ? VSYNC_POL : ~VSYNC_POL;

  // Stage 1 captures region/sync for pixel n; stage 2 pairs it with the colour
  // the source returns one strobe later, so colour and syncs leave together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act1_q  <= 1'b0;
      hs1_q   <= ~HSYNC_POL;
      vs1_q   <= ~VSYNC_POL;
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
      hsync_q <= ~HSYNC_POL;
      vsync_q <= ~VSYNC_POL;
    end else if (pix_en) begin
      act1_q  <= active;
      hs1_q   <= hsLevel;
      vs1_q   <= vsLevel;
      red_q   <= act1_q ? pix_rgb[3*RGB_W-1 -: RGB_W] : '0;
      green_q <= act1_q ? pix_rgb[2*RGB_W-1 -: RGB_W] : '0;
      blue_q  <= act1_q ? pix_rgb[RGB_W-1 -: RGB_W]   : '0;
      hsync_q <= hs1_q;
      vsync_q <= vs1_q;
    end
  end

  assign red   = red_q;
  assign green = green_q;
  assign blue  = blue_q;
  assign hsync = hsync_q;
  assign vsync = vsync_q;

endmodule
